// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter:
// FSM states, owner identity and the legal memory read latency range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_CNT_W   = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one synchronous
// memory port: round-robin on ties, one access in flight, fixed read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Out-of-range latencies are clamped so the counter width always suffices.
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    arb_state_t            state, state_nxt;
    owner_t                owner, last_owner, sel_owner;
    logic                  sel_valid;
    logic                  lat_we;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0]     lat_addr;
    logic [DATA_W-1:0]     lat_wdata;
    logic                  issue, resp, capture;

    always_comb begin
        state_nxt = state;
        sel_owner = owner;
        sel_valid = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    sel_valid = 1'b1;
                    if (if_req && ls_req)
                        sel_owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
                    else
                        sel_owner = ls_req ? OWN_LS : OWN_IF;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we)
                    state_nxt = IDLE;
                else if (LAT > 1)
                    state_nxt = WAIT;
                else
                    state_nxt = RESP;
            end
            WAIT: begin
                if (lat_cnt == LAT_CNT_W'(1))
                    state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign issue = (state == ISSUE);
    assign resp  = (state == RESP);
    // Read data is taken on the last cycle of the latency window.
    assign capture = (issue && !lat_we && LAT == 1) ||
                     (state == WAIT && lat_cnt == LAT_CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_LS;
            lat_cnt    <= '0;
            lat_we     <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (sel_valid) begin
                owner  <= sel_owner;
                lat_we <= (sel_owner == OWN_LS) && ls_we;
            end
            if (issue) begin
                last_owner <= owner;
                lat_cnt    <= LAT_CNT_W'(LAT - 1);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            end
            if (capture) begin
                if (owner == OWN_IF)
                    if_rdata <= mem_rdata;
                else
                    ls_rdata <= mem_rdata;
            end
        end
    end

    // Address/data latches are only observed while in ISSUE, so they carry no reset.
    always_ff @(posedge clk) begin
        if (sel_valid) begin
            lat_addr  <= (sel_owner == OWN_LS) ? ls_addr : if_addr;
            lat_wdata <= (sel_owner == OWN_LS) ? ls_wdata : '0;
        end
    end

    assign mem_en    = issue;
    assign mem_we    = issue && lat_we;
    assign mem_addr  = issue ? lat_addr : '0;
    assign mem_wdata = issue ? lat_wdata : '0;
    assign if_gnt    = issue && (owner == OWN_IF);
    assign ls_gnt    = issue && (owner == OWN_LS);
    assign if_rvalid = resp && (owner == OWN_IF);
    assign ls_rvalid = resp && (owner == OWN_LS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3), each
// driven by directed and random requesters and compared every cycle to a model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input int lat, input string name,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [lat=%0d] %s: got %h expected %h", lat, name, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [5:0] a);
        case (a)
            6'h04:   return 32'h00500093;
            6'h08:   return 32'h00001234;
            6'h09:   return 32'h0000ABCD;
            default: return {a, a, a, a, a, 2'b10} ^ 32'h13572468;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 1 : 3;

        logic              rst_n = 1'b0;
        logic              if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
        logic [ADDR_W-1:0] if_addr = '0, ls_addr = '0;
        logic [DATA_W-1:0] ls_wdata = '0;
        logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
        logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
        logic [ADDR_W-1:0] mem_addr;
        logic [5:0]        ctrl;
        bit                done = 1'b0;
        int                cyc = 0;

        mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(L)) dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
            .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        assign ctrl = {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we};

        // Memory device: written words overlay the fixed initial contents;
        // read data appears on the last cycle of an L-cycle window.
        logic [DATA_W-1:0] dev_mem [64];
        logic [63:0]       wr_valid = '0;
        logic [DATA_W-1:0] pipe [4];
        logic [DATA_W-1:0] dev_rd;
        assign dev_rd    = wr_valid[mem_addr] ? dev_mem[mem_addr] : init_word(mem_addr);
        assign mem_rdata = (L == 1) ? dev_rd : pipe[(L > 1) ? L - 2 : 0];

        always @(posedge clk) begin
            pipe[0] <= dev_rd;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            if (mem_en && mem_we) begin
                dev_mem[mem_addr]  <= mem_wdata;
                wr_valid[mem_addr] <= 1'b1;
            end
        end

        // Transaction-level model: a request seen in an idle cycle k is granted
        // in k+1, read data returns in k+1+L, and the port is idle again after.
        int          m_free = 0, m_gnt = -1, m_rv = -1;
        bit          m_ls = 1'b0, m_last_ls = 1'b1, m_we = 1'b0;
        logic [5:0]  m_addr = '0;
        logic [31:0] m_wd = '0, m_rd = '0, m_ifr = '0, m_lsr = '0;
        logic [31:0] model_mem [64];

        initial begin
            for (int a = 0; a < 64; a++) model_mem[a] = init_word(6'(a));
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst_n) begin
                    m_free = cyc; m_gnt = -1; m_rv = -1; m_last_ls = 1'b1;
                    m_ifr = '0; m_lsr = '0;
                end else begin
                    if (cyc - 1 >= m_free && (if_req || ls_req)) begin
                        m_ls      = (if_req && ls_req) ? !m_last_ls : ls_req;
                        m_last_ls = m_ls;
                        m_gnt     = cyc;
                        m_we      = m_ls && ls_we;
                        m_addr    = m_ls ? ls_addr : if_addr;
                        m_wd      = m_ls ? ls_wdata : '0;
                        if (m_we) begin
                            model_mem[m_addr] = m_wd;
                            m_rv   = -1;
                            m_free = cyc + 1;
                        end else begin
                            m_rd   = model_mem[m_addr];
                            m_rv   = cyc + L;
                            m_free = cyc + L + 1;
                        end
                    end
                    if (cyc == m_rv) begin
                        if (m_ls) m_lsr = m_rd;
                        else      m_ifr = m_rd;
                    end
                end
            end
        end

        initial begin
            logic [5:0]  e_ctrl;
            logic [5:0]  e_addr;
            logic [31:0] e_wd, e_ifr, e_lsr;
            bit          en, rv;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    e_ctrl = '0; e_addr = '0; e_wd = '0; e_ifr = '0; e_lsr = '0;
                end else begin
                    en     = (cyc == m_gnt);
                    rv     = (cyc == m_rv);
                    e_ctrl = {en && !m_ls, rv && !m_ls, en && m_ls, rv && m_ls, en, en && m_we};
                    e_addr = en ? m_addr : '0;
                    e_wd   = en ? m_wd : '0;
                    e_ifr  = m_ifr;
                    e_lsr  = m_lsr;
                end
                check(L, "ctrl{ig,iv,lg,lv,en,we}", 32'(ctrl), 32'(e_ctrl));
                check(L, "mem_addr", 32'(mem_addr), 32'(e_addr));
                check(L, "mem_wdata", mem_wdata, e_wd);
                check(L, "if_rdata", if_rdata, e_ifr);
                check(L, "ls_rdata", ls_rdata, e_lsr);
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic do_if(input logic [5:0] a, output int gc);
            int n = 0;
            if_addr = a;
            if_req  = 1'b1;
            do begin step(); n++; end while (!if_gnt && n < 60);
            check(L, "if_gnt_seen", 32'(if_gnt), 32'd1);
            gc     = cyc;
            if_req = 1'b0;
        endtask

        task automatic do_ls(input logic we, input logic [5:0] a,
                             input logic [31:0] wd, output int gc);
            int n = 0;
            ls_we    = we;
            ls_addr  = a;
            ls_wdata = wd;
            ls_req   = 1'b1;
            do begin step(); n++; end while (!ls_gnt && n < 60);
            check(L, "ls_gnt_seen", 32'(ls_gnt), 32'd1);
            gc     = cyc;
            ls_req = 1'b0;
        endtask

        task automatic wait_rv(input bit ls, output int rc);
            int n = 0;
            do begin step(); n++; end
            while (!(ls ? ls_rvalid : if_rvalid) && n < 60);
            check(L, ls ? "ls_rvalid_seen" : "if_rvalid_seen",
                  32'(ls ? ls_rvalid : if_rvalid), 32'd1);
            rc = cyc;
        endtask

        initial begin
            int c0, gc, rc, cnt, n, k, first_ls, gc_a, gc_b;
            int order [4];
            int gcs [4];

            repeat (3) @(posedge clk);
            @(negedge clk);
            check(L, "reset_ctrl", 32'(ctrl), 32'd0);
            check(L, "reset_if_rdata", if_rdata, 32'd0);
            check(L, "reset_ls_rdata", ls_rdata, 32'd0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            step();

            // single fetch
            c0 = cyc;
            do_if(6'h04, gc);
            check(L, "rd_gnt_cycle", gc - c0, 32'd1);
            check(L, "rd_mem_en", 32'(mem_en), 32'd1);
            check(L, "rd_mem_addr", 32'(mem_addr), 32'h04);
            check(L, "rd_mem_we", 32'(mem_we), 32'd0);
            wait_rv(1'b0, rc);
            check(L, "rd_rvalid_lat", rc - gc, L);
            check(L, "rd_if_rdata", if_rdata, 32'h00500093);
            check(L, "rd_ls_rdata", ls_rdata, 32'd0);
            step();

            // store then load
            do_ls(1'b1, 6'h10, 32'hDEADBEEF, gc);
            check(L, "sw_mem_we", 32'(mem_we), 32'd1);
            check(L, "sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
            cnt = 0;
            repeat (L + 3) begin step(); cnt += ls_rvalid; end
            check(L, "sw_no_rvalid", cnt, 32'd0);
            do_ls(1'b0, 6'h10, 32'd0, gc);
            wait_rv(1'b1, rc);
            check(L, "lw_ls_rdata", ls_rdata, 32'hDEADBEEF);
            step();

            // tie after reset, continuous requests
            rst_n = 1'b0;
            step();
            rst_n   = 1'b1;
            if_addr = 6'h04; ls_we = 1'b0; ls_addr = 6'h10;
            if_req  = 1'b1;  ls_req = 1'b1;
            for (int i = 0; i < 4; i++) begin order[i] = 2; gcs[i] = 0; end
            n = 0; k = 0;
            while (k < 4 && n < 200) begin
                step(); n++;
                if (if_gnt || ls_gnt) begin order[k] = int'(ls_gnt); gcs[k] = cyc; k++; end
            end
            if_req = 1'b0; ls_req = 1'b0;
            check(L, "tie_grants", k, 32'd4);
            for (int i = 0; i < 4; i++) check(L, "tie_order", order[i], i % 2);
            check(L, "tie_spacing", gcs[1] - gcs[0], L + 2);
            repeat (L + 2) step();

            // LS request during a busy fetch waits for the next idle
            do_if(6'h04, gc);
            ls_we = 1'b0; ls_addr = 6'h08; ls_req = 1'b1;
            n = 0; first_ls = -1; rc = -1;
            while (first_ls < 0 && n < 60) begin
                step(); n++;
                if (if_rvalid) rc = cyc;
                if (ls_gnt) first_ls = cyc;
            end
            ls_req = 1'b0;
            check(L, "busy_if_rvalid", rc - gc, L);
            check(L, "busy_ls_gnt", first_ls - gc, L + 2);
            wait_rv(1'b1, rc);
            check(L, "busy_ls_rdata", ls_rdata, 32'h00001234);
            step();

            // the other requester's data is retained
            do_if(6'h09, gc);
            wait_rv(1'b0, rc);
            check(L, "keep_if_rdata", if_rdata, 32'h0000ABCD);
            check(L, "keep_ls_rdata", ls_rdata, 32'h00001234);
            step();

            // reset in the middle of a read
            do_if(6'h09, gc);
            step();
            rst_n = 1'b0;
            #1;
            check(L, "rst_mid_ctrl", 32'(ctrl), 32'd0);
            check(L, "rst_mid_if_rdata", if_rdata, 32'd0);
            check(L, "rst_mid_ls_rdata", ls_rdata, 32'd0);
            check(L, "rst_mid_mem_addr", 32'(mem_addr), 32'd0);
            step();
            rst_n = 1'b1;
            cnt = 0;
            repeat (L + 3) begin step(); cnt += int'(if_rvalid) + int'(ls_rvalid); end
            check(L, "rst_no_stray_rvalid", cnt, 32'd0);
            do_if(6'h04, gc);
            wait_rv(1'b0, rc);
            check(L, "rst_after_lat", rc - gc, L);
            check(L, "rst_after_rdata", if_rdata, 32'h00500093);
            step();

            // random traffic from both requesters
            fork
                begin
                    for (int t = 0; t < 40; t++) begin
                        repeat ($urandom_range(0, 3)) step();
                        do_if(6'($urandom_range(0, 63)), gc_a);
                    end
                end
                begin
                    for (int t = 0; t < 40; t++) begin
                        repeat ($urandom_range(0, 3)) step();
                        do_ls(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                              $urandom, gc_b);
                    end
                end
            join
            repeat (10) step();
            done = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(u[0].done && u[1].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check(0, "both_instances_done", 32'(u[0].done && u[1].done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
